block_draw: RTL and testbench

BLOCK_DRAW -- requirements
Module: block_draw

---
 rtl/block_draw.sv | 120 ++++++++++++
 tb/tb_block_draw.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_draw.sv
// Rasterises a WIDTH x HEIGHT solid block at (pos_x, Y_TOP), one pixel per clock, scrolling left per frame tick.
// Optional BLOCK_DRAW_CLIP_EN blanks pixels at or beyond X_MAX without changing draw latency.
module block_draw #(
   parameter logic [10:0] X_START = 11'd100,
   parameter logic [10:0] Y_TOP   = 11'd100,
   parameter logic [7:0]  WIDTH   = 8'd4,
   parameter logic [7:0]  HEIGHT  = 8'd2,
   parameter logic [2:0]  COLOUR  = 3'b111,
   parameter logic [10:0] STEP    = 11'd4,
   parameter logic [10:0] X_MAX   = 11'd160
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        shape_reset,
   input  logic        draw_start,
   input  logic        update_screen,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic [2:0]  colour,
   output logic        draw_done,
   output logic [10:0] pos_x
);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   localparam logic [7:0] W_LAST = WIDTH - 8'd1;
   localparam logic [7:0] H_LAST = HEIGHT - 8'd1;

   state_t      state_q, state_d;
   logic [7:0]  cx_q, cx_d;
   logic [7:0]  cy_q, cy_d;
   logic [10:0] pos_x_q, pos_x_d;
   logic        pend_q, pend_d;

   logic [10:0] moved_x;
   logic        move_req;
   logic        last_px;

   // Wrap to the start column rather than underflow past the left edge.
   assign moved_x  = (pos_x_q < STEP) ? X_START : (pos_x_q - STEP);
   assign move_req = pend_q | update_screen;
   assign last_px  = (cx_q == W_LAST) && (cy_q == H_LAST);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cx_q    <= 8'd0;
         cy_q    <= 8'd0;
         pos_x_q <= X_START;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         pos_x_q <= pos_x_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      pos_x_d = pos_x_q;
      pend_d  = pend_q;
      if (shape_reset) begin
         state_d = IDLE;
         cx_d    = 8'd0;
         cy_d    = 8'd0;
         pos_x_d = X_START;
         pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (update_screen) pos_x_d = moved_x;
               if (draw_start) begin
                  state_d = DRAW;
                  cx_d    = 8'd0;
                  cy_d    = 8'd0;
               end
            end
            DRAW: begin
               // Moves are deferred to the frame boundary so a frame never straddles two positions.
               if (!draw_start || last_px) begin
                  state_d = draw_start ? DONE : IDLE;
                  cx_d    = 8'd0;
                  cy_d    = 8'd0;
                  pend_d  = 1'b0;
                  if (move_req) pos_x_d = moved_x;
               end else begin
                  pend_d = move_req;
                  if (cx_q == W_LAST) begin
                     cx_d = 8'd0;
                     cy_d = cy_q + 8'd1;
                  end else begin
                     cx_d = cx_q + 8'd1;
                  end
               end
            end
            DONE: begin
               if (update_screen) pos_x_d = moved_x;
               if (!draw_start) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign x         = pos_x_q + {3'b000, cx_q};
   assign y         = Y_TOP + {3'b000, cy_q};
   assign draw_done = (state_q == DONE);
   assign pos_x     = pos_x_q;

`ifdef BLOCK_DRAW_CLIP_EN
   assign colour = ((state_q == DRAW) && (x < X_MAX)) ? COLOUR : 3'b000;
`else
   assign colour = (state_q == DRAW) ? COLOUR : 3'b000;
`endif

endmodule

// File: tb/tb_block_draw.sv
// Bench for block_draw: directed frame scenarios plus randomized controller traffic against a frame-level model.
module tb_block_draw;

   logic        clock = 1'b0;
   logic        resetn;
   logic        shape_reset;
   logic        draw_start;
   logic        update_screen;
   logic [10:0] x, y, pos_x;
   logic [2:0]  colour;
   logic        draw_done;

   logic        c_sr, c_ds, c_us;
   logic [10:0] c_x, c_y, c_pos_x;
   logic [2:0]  c_colour;
   logic        c_draw_done;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   block_draw u_dut (
      .clock(clock), .resetn(resetn), .shape_reset(shape_reset),
      .draw_start(draw_start), .update_screen(update_screen),
      .x(x), .y(y), .colour(colour), .draw_done(draw_done), .pos_x(pos_x)
   );

   block_draw #(.X_START(11'd158)) u_clip (
      .clock(clock), .resetn(resetn), .shape_reset(c_sr),
      .draw_start(c_ds), .update_screen(c_us),
      .x(c_x), .y(c_y), .colour(c_colour), .draw_done(c_draw_done), .pos_x(c_pos_x)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Frame-level model: mode 0 idle, 1 drawing pixel number m_k of the frame, 2 frame complete.
   int          m_mode;
   int          m_k;
   int          m_pos;
   bit          m_pend;

   function automatic int moved(input int p);
      return (p < 4) ? 100 : p - 4;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_k = 0; m_pos = 100; m_pend = 0;
   endtask

   task automatic model_step();
      bit want_move;
      if (shape_reset) begin
         model_reset();
      end else if (m_mode == 0) begin
         if (update_screen) m_pos = moved(m_pos);
         if (draw_start) begin m_mode = 1; m_k = 0; end
      end else if (m_mode == 1) begin
         want_move = m_pend || update_screen;
         if (!draw_start || m_k == 4 * 2 - 1) begin
            m_mode = draw_start ? 2 : 0;
            m_k = 0;
            m_pend = 0;
            if (want_move) m_pos = moved(m_pos);
         end else begin
            m_k++;
            m_pend = want_move;
         end
      end else begin
         if (update_screen) m_pos = moved(m_pos);
         if (!draw_start) m_mode = 0;
      end
   endtask

   task automatic check_model(input string tag);
      int ex;
      ex = (m_pos + m_k % 4) % 2048;
      check({tag, ".x"}, x, ex);
      check({tag, ".y"}, y, 100 + m_k / 4);
      check({tag, ".colour"}, colour, (m_mode == 1) ? 7 : 0);
      check({tag, ".draw_done"}, draw_done, (m_mode == 2) ? 1 : 0);
      check({tag, ".pos_x"}, pos_x, m_pos);
   endtask

   task automatic tick(input string tag);
      @(posedge clock);
      #1;
      model_step();
      check_model(tag);
   endtask

   task automatic pulse_update(input string tag);
      update_screen = 1'b1;
      tick(tag);
      update_screen = 1'b0;
   endtask

   initial begin
      resetn = 1'b1; shape_reset = 1'b0; draw_start = 1'b0; update_screen = 1'b0;
      c_sr = 1'b0; c_ds = 1'b0; c_us = 1'b0;
      model_reset();

      // Asynchronous reset mid-cycle, outputs checked before any clock edge.
      #2 resetn = 1'b0;
      #1;
      check("rst.x", x, 100);
      check("rst.y", y, 100);
      check("rst.colour", colour, 0);
      check("rst.draw_done", draw_done, 0);
      check("rst.pos_x", pos_x, 100);
      repeat (2) @(posedge clock);
      @(negedge clock) resetn = 1'b1;
      tick("idle");

      // First frame: 8 pixels raster order, done from cycle 9, release at 12.
      draw_start = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick("frame1");
         check("frame1.x_abs", x, 100 + (i - 1) % 4);
         check("frame1.y_abs", y, 100 + (i - 1) / 4);
         check("frame1.col_abs", colour, 7);
      end
      for (int i = 9; i <= 12; i++) begin
         tick("frame1_done");
         check("frame1.done_abs", draw_done, 1);
      end
      draw_start = 1'b0;
      tick("release");
      check("release.done_abs", draw_done, 0);

      // Move in IDLE, then a frame at the new position.
      pulse_update("idle_move");
      check("idle_move.pos_abs", pos_x, 96);
      draw_start = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick("frame2");
         check("frame2.x_abs", x, 96 + (i - 1) % 4);
      end
      tick("frame2_done");
      draw_start = 1'b0;
      tick("frame2_idle");

      // Two pulses during DRAW: pixels stay put, a single step at DONE.
      shape_reset = 1'b1;
      tick("sr1");
      shape_reset = 1'b0;
      draw_start = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         if (i == 2 || i == 5) update_screen = 1'b1;
         tick("frame3");
         update_screen = 1'b0;
         check("frame3.x_abs", x, 100 + (i - 1) % 4);
      end
      tick("frame3_done");
      check("frame3.pos_abs", pos_x, 96);
      check("frame3.done_abs", draw_done, 1);
      draw_start = 1'b0;
      tick("frame3_idle");

      // shape_reset during DRAW with a move pending, draw_start still held.
      draw_start = 1'b1;
      tick("frame4");
      update_screen = 1'b1;
      tick("frame4");
      update_screen = 1'b0;
      tick("frame4");
      tick("frame4");
      shape_reset = 1'b1;
      tick("sr_draw");
      check("sr_draw.pos_abs", pos_x, 100);
      check("sr_draw.done_abs", draw_done, 0);
      check("sr_draw.col_abs", colour, 0);
      shape_reset = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick("frame5");
         check("frame5.pos_abs", pos_x, 100);
      end
      draw_start = 1'b0;
      tick("frame5_idle");

      // Walk down to column 0, then wrap.
      for (int i = 1; i <= 25; i++) pulse_update("walk");
      check("walk.pos_zero", pos_x, 0);
      pulse_update("wrap");
      check("wrap.pos_abs", pos_x, 100);

      // Clipping instance starting at 158.
      c_ds = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick("clip_main");
         if (i <= 8) begin
            check("clip.x", c_x, 158 + (i - 1) % 4);
            check("clip.y", c_y, 100 + (i - 1) / 4);
`ifdef BLOCK_DRAW_CLIP_EN
            check("clip.colour", c_colour, (158 + (i - 1) % 4 >= 160) ? 0 : 7);
`else
            check("clip.colour", c_colour, 7);
`endif
            check("clip.done_low", c_draw_done, 0);
         end else begin
            check("clip.done", c_draw_done, 1);
         end
      end
      c_ds = 1'b0;

      // Randomized controller traffic, including aborts and resets.
      for (int n = 0; n < 3000; n++) begin
         shape_reset   = ($urandom_range(0, 63) == 0);
         update_screen = ($urandom_range(0, 7) == 0);
         if (!draw_start) draw_start = ($urandom_range(0, 3) == 0);
         else if (draw_done) draw_start = ($urandom_range(0, 1) == 0);
         else draw_start = ($urandom_range(0, 31) != 0);
         tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
